// File: rtl/mux4_rr_arbiter_pkg.sv
// arb_pkg: shared sizes, FSM encodings and one-hot helper for the round-robin arbiter
package arb_pkg;
  localparam int NREQ = 4;
  localparam int SEL_W = 2;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NREQ'(1) << i;
  endfunction
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant bundle between requesters and the arbiter
interface mux4_rr_arbiter_if;
  import arb_pkg::*;
  logic [NREQ-1:0] req;
  logic done;
  logic [NREQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic busy;
  logic timeout_err;
  modport master (output req, done, input gnt, sel, busy, timeout_err);
  modport slave (input req, done, output gnt, sel, busy, timeout_err);
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// rr_pick: first unmasked request at or after ptr, searching upward modulo 4
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [NREQ-1:0] eff;
  logic [NREQ-1:0] rot;
  logic [SEL_W-1:0] off;
  assign eff = req & ~mask;
  assign rot = NREQ'({eff, eff} >> ptr);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign found = |eff;
  assign idx = ptr + off;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant of a shared 4:1 muxed resource with completion watchdog
module mux4_rr_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  mux4_rr_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  logic [0:0] state;
  logic [SEL_W-1:0] ptr, sel_q, pick_ptr, idx;
  logic [NREQ-1:0] gnt_q, pick_mask;
  logic [CNT_W-1:0] cnt;
  logic busy_q, terr_q, found, expire, rel;
  assign expire = cnt == LAST;
  assign rel = bus.done || !bus.req[sel_q] || expire;
  assign pick_ptr = state == ST_GRANT ? sel_q + 2'd1 : ptr;
  assign pick_mask = state == ST_GRANT ? onehot(sel_q) : '0;
  rr_pick u_pick (
    .req(bus.req),
    .ptr(pick_ptr),
    .mask(pick_mask),
    .found(found),
    .idx(idx)
  );
  // grant FSM: arbitrate from IDLE, hold in GRANT, re-arbitrate back-to-back on release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      busy_q <= 1'b0;
      terr_q <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else if (state == ST_IDLE) begin
      terr_q <= 1'b0;
      if (found) begin
        state <= ST_GRANT;
        gnt_q <= onehot(idx);
        sel_q <= idx;
        busy_q <= 1'b1;
        cnt <= '0;
      end
    end else if (rel) begin
      ptr <= sel_q + 2'd1;
      terr_q <= expire && !bus.done && bus.req[sel_q];
      cnt <= '0;
      if (found) begin
        gnt_q <= onehot(idx);
        sel_q <= idx;
      end else begin
        state <= ST_IDLE;
        gnt_q <= '0;
        busy_q <= 1'b0;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
      terr_q <= 1'b0;
    end
  assign bus.gnt = gnt_q;
  assign bus.sel = sel_q;
  assign bus.busy = busy_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed vectors with hand-computed grants for the round-robin arbiter
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  mux4_rr_arbiter_if bif ();
  mux4_rr_arbiter #(.TIMEOUT(8), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bif.req = 4'b0000;
    bif.done = 1'b0;
    #1;
    chk("rst_gnt", 32'(bif.gnt), 0);
    chk("rst_sel", 32'(bif.sel), 0);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_terr", 32'(bif.timeout_err), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_gnt", 32'(bif.gnt), 0);
    bif.req = 4'b0100;
    tick();
    chk("g2_gnt", 32'(bif.gnt), 32'h4);
    chk("g2_sel", 32'(bif.sel), 2);
    chk("g2_busy", 32'(bif.busy), 1);
    bif.done = 1'b1;
    tick();
    bif.done = 1'b0;
    bif.req = 4'b0000;
    chk("rel_gnt", 32'(bif.gnt), 0);
    chk("rel_busy", 32'(bif.busy), 0);
    chk("rel_sel", 32'(bif.sel), 2);
    bif.done = 1'b1;
    tick();
    bif.done = 1'b0;
    chk("idle_done_gnt", 32'(bif.gnt), 0);
    chk("idle_done_busy", 32'(bif.busy), 0);
    chk("idle_done_terr", 32'(bif.timeout_err), 0);
    bif.req = 4'b1000;
    tick();
    chk("g3_gnt", 32'(bif.gnt), 32'h8);
    tick();
    bif.req = 4'b0000;
    tick();
    chk("wd_gnt", 32'(bif.gnt), 0);
    chk("wd_busy", 32'(bif.busy), 0);
    chk("wd_terr", 32'(bif.timeout_err), 0);
    bif.req = 4'b1010;
    tick();
    chk("ptr0_sel", 32'(bif.sel), 1);
    chk("ptr0_gnt", 32'(bif.gnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(bif.gnt), 0);
    chk("arst_busy", 32'(bif.busy), 0);
    chk("arst_sel", 32'(bif.sel), 0);
    #1 rst_n = 1'b1;
    bif.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        bif.done = 1'b0;
        chk($sformatf("rr%0d_sel", g), 32'(bif.sel), 32'(g % 4));
        chk($sformatf("rr%0d_hot", g), 32'($countones(bif.gnt)), 1);
        chk($sformatf("rr%0d_gnt", g), 32'(bif.gnt), 32'(1 << (g % 4)));
      end
      bif.done = 1'b1;
      if (g == 4) bif.req = 4'b0000;
    end
    tick();
    bif.done = 1'b0;
    chk("rr_end_gnt", 32'(bif.gnt), 0);
    bif.req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("to%0d_gnt", i), 32'(bif.gnt), 32'h2);
      chk($sformatf("to%0d_terr", i), 32'(bif.timeout_err), 0);
    end
    bif.req = 4'b1111;
    tick();
    chk("to_rev_gnt", 32'(bif.gnt), 32'h4);
    chk("to_rev_sel", 32'(bif.sel), 2);
    chk("to_rev_terr", 32'(bif.timeout_err), 1);
    tick();
    chk("to_after_terr", 32'(bif.timeout_err), 0);
    chk("to_after_gnt", 32'(bif.gnt), 32'h4);
    repeat (6) tick();
    chk("co_hold_gnt", 32'(bif.gnt), 32'h4);
    bif.done = 1'b1;
    tick();
    bif.done = 1'b0;
    chk("co_gnt", 32'(bif.gnt), 32'h8);
    chk("co_sel", 32'(bif.sel), 3);
    chk("co_terr", 32'(bif.timeout_err), 0);
    tick();
    chk("co_after_terr", 32'(bif.timeout_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
